fml_arb4: RTL and testbench

- Four-master to one-slave FML arbiter.
- Sits directly downstream of the Wishbone-to-FML bridges (CPU data/instruction bridges, DMA masters) and upstream of the single FML memory controller port.
- Grants one master at a time with round-robin priority, muxes its request onto the slave port, and routes the acknowledge back.
- Single-beat transfers only; a request is held until acked.

---
 rtl/fml_arb4_pkg.sv | 11 +
 rtl/fml_rr_pick4.sv | 29 ++
 rtl/fml_arb4.sv | 87 ++++++++
 tb/tb_fml_arb4.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fml_arb4_pkg.sv
// Shared types and constants for the FML arbiter family.
package fml_arb4_pkg;

    localparam int NMASTERS = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/fml_rr_pick4.sv
// Round-robin picker: first requester after `last`, scanning upward mod 4.
module fml_rr_pick4
    import fml_arb4_pkg::*;
(
    input  logic [NMASTERS-1:0] req,
    input  logic [1:0]          last,
    output logic [1:0]          grant,
    output logic                valid
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        grant = last;
        found = 1'b0;
        idx   = last;
        // last itself is checked last, so a master that was just served loses ties
        for (int k = 1; k <= NMASTERS; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/fml_arb4.sv
// Four-master to one-slave FML arbiter with round-robin grant and single-beat transfers.
module fml_arb4
    import fml_arb4_pkg::*;
#(
    parameter int fml_depth = 25
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic [NMASTERS*fml_depth-1:0]   m_adr,
    input  logic [NMASTERS-1:0]             m_stb,
    input  logic [NMASTERS-1:0]             m_we,
    input  logic [NMASTERS*4-1:0]           m_sel,
    input  logic [NMASTERS*32-1:0]          m_do,
    output logic [NMASTERS-1:0]             m_ack,
    output logic [31:0]                     m_di,
    output logic [fml_depth-1:0]            s_adr,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [3:0]                      s_sel,
    output logic [31:0]                     s_do,
    input  logic                            s_ack,
    input  logic [31:0]                     s_di
);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] pick_grant;
    logic       pick_valid;

    fml_rr_pick4 u_pick (
        .req   (m_stb),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // a withdrawn strobe is treated like a completed transfer for fairness
                if (s_ack || !m_stb[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr = m_adr[grant_q*fml_depth +: fml_depth];
        s_we  = m_we[grant_q];
        s_sel = m_sel[grant_q*4 +: 4];
        s_do  = m_do[grant_q*32 +: 32];
        s_stb = 1'b0;
        m_ack = '0;
        if (state_q == BUSY) begin
            s_stb          = m_stb[grant_q];
            m_ack[grant_q] = s_ack;
        end
    end

    assign m_di = s_di;

endmodule

// File: tb/tb_fml_arb4.sv
// Directed bench for fml_arb4: rotation, fairness, write muxing, reset abort, stb withdrawal.
module tb_fml_arb4;
    localparam int FD = 25;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [4*FD-1:0] m_adr;
    logic [3:0]      m_stb, m_we;
    logic [15:0]     m_sel;
    logic [127:0]    m_do;
    logic [3:0]      m_ack;
    logic [31:0]     m_di;
    logic [FD-1:0]   s_adr;
    logic            s_stb, s_we;
    logic [3:0]      s_sel;
    logic [31:0]     s_do;
    logic            s_ack;
    logic [31:0]     s_di;

    int checks = 0;
    int errors = 0;

    logic [FD-1:0] adr_tab [4];
    int            order [4];

    always #5 sys_clk = ~sys_clk;

    fml_arb4 #(.fml_depth(FD)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_adr(m_adr), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_do(m_do),
        .m_ack(m_ack), .m_di(m_di),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_do(s_do),
        .s_ack(s_ack), .s_di(s_di)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        adr_tab[0] = 25'h0001000;
        adr_tab[1] = 25'h0000100;
        adr_tab[2] = 25'h0002000;
        adr_tab[3] = 25'h0003000;
        for (int i = 0; i < 4; i++) m_adr[i*FD +: FD] = adr_tab[i];
        m_do  = {32'h33330003, 32'h22220002, 32'h11110001, 32'h00000000};
        m_sel = 16'hFFFF;
        m_we  = 4'b0000;
        m_stb = 4'b0000;
        s_ack = 1'b0;
        s_di  = 32'hDEADBEEF;
        sys_rst = 1'b0;
        step(); step();
        chk("rst_s_stb", {31'd0, s_stb}, 32'd0);
        chk("rst_m_ack", {28'd0, m_ack}, 32'd0);
        sys_rst = 1'b1;
        step();

        // single master 1, slave acks 3 cycles after s_stb
        m_stb = 4'b0010;
        #1 chk("t1_idle_stb", {31'd0, s_stb}, 32'd0);
        step();
        chk("t1_s_stb", {31'd0, s_stb}, 32'd1);
        chk("t1_s_adr", {7'd0, s_adr}, 32'h00000100);
        chk("t1_ack0", {28'd0, m_ack}, 32'd0);
        step(); chk("t1_ack1", {28'd0, m_ack}, 32'd0);
        step(); chk("t1_ack2", {28'd0, m_ack}, 32'd0);
        step();
        s_ack = 1'b1;
        #1 chk("t1_ack", {28'd0, m_ack}, 32'b0010);
        chk("t1_m_di", m_di, 32'hDEADBEEF);
        step();
        m_stb = 4'b0000; s_ack = 1'b0;
        #1 chk("t1_ack_after", {28'd0, m_ack}, 32'd0);
        chk("t1_stb_after", {31'd0, s_stb}, 32'd0);

        // fresh reset, all four request together, first-BUSY-cycle ack
        sys_rst = 1'b0; step(); sys_rst = 1'b1;
        m_stb = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t2_adr%0d", k), {7'd0, s_adr}, {7'd0, adr_tab[k]});
            chk($sformatf("t2_stb%0d", k), {31'd0, s_stb}, 32'd1);
            s_ack = 1'b1;
            #1 chk($sformatf("t2_ack%0d", k), {28'd0, m_ack}, 32'd1 << k);
            step();
            m_stb[k] = 1'b0; s_ack = 1'b0;
            #1 chk($sformatf("t2_idle%0d", k), {27'd0, s_stb, m_ack}, 32'd0);
        end

        // fairness: 0 and 2 hold stb continuously
        order = '{0, 2, 0, 2};
        m_stb = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("t3_adr%0d", k), {7'd0, s_adr}, {7'd0, adr_tab[order[k]]});
            s_ack = 1'b1;
            #1 chk($sformatf("t3_ack%0d", k), {28'd0, m_ack}, 32'd1 << order[k]);
            step();
            s_ack = 1'b0;
            #1 chk($sformatf("t3_idle%0d", k), {31'd0, s_stb}, 32'd0);
        end
        m_stb = 4'b0000;

        // write path from master 3
        m_we = 4'b1000;
        m_sel = 16'h5FFF;
        m_do[96 +: 32] = 32'h12345678;
        m_stb = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_we%0d", k), {31'd0, s_we}, 32'd1);
            chk($sformatf("t4_sel%0d", k), {28'd0, s_sel}, 32'b0101);
            chk($sformatf("t4_do%0d", k), s_do, 32'h12345678);
            chk($sformatf("t4_stb%0d", k), {31'd0, s_stb}, 32'd1);
        end
        s_ack = 1'b1;
        #1 chk("t4_ack", {28'd0, m_ack}, 32'b1000);
        step();
        s_ack = 1'b0; m_stb = 4'b0000; m_we = 4'b0000;

        // reset mid-transaction on master 1
        sys_rst = 1'b0; step(); sys_rst = 1'b1;
        m_stb = 4'b0010;
        step();
        chk("t5_busy_adr", {7'd0, s_adr}, {7'd0, adr_tab[1]});
        chk("t5_busy_stb", {31'd0, s_stb}, 32'd1);
        sys_rst = 1'b0;
        step();
        sys_rst = 1'b1; s_ack = 1'b1;
        #1 chk("t5_rst_stb", {31'd0, s_stb}, 32'd0);
        chk("t5_rst_ack", {28'd0, m_ack}, 32'd0);
        s_ack = 1'b0;
        m_stb = 4'b0011;
        step();
        chk("t5_first", {7'd0, s_adr}, {7'd0, adr_tab[0]});
        s_ack = 1'b1;
        #1 chk("t5_ack0", {28'd0, m_ack}, 32'b0001);
        step();
        s_ack = 1'b0; m_stb = 4'b0010;
        step();
        chk("t5_second", {7'd0, s_adr}, {7'd0, adr_tab[1]});
        s_ack = 1'b1;
        #1 chk("t5_ack1", {28'd0, m_ack}, 32'b0010);
        step();
        s_ack = 1'b0; m_stb = 4'b0000;

        // stb withdrawal by master 2 with master 3 pending
        m_stb = 4'b1100;
        step();
        chk("t6_adr2", {7'd0, s_adr}, {7'd0, adr_tab[2]});
        m_stb = 4'b1000;
        #1 chk("t6_drop_stb", {31'd0, s_stb}, 32'd0);
        step();
        chk("t6_idle_stb", {31'd0, s_stb}, 32'd0);
        s_ack = 1'b1;
        #1 chk("t6_late_ack", {28'd0, m_ack}, 32'd0);
        s_ack = 1'b0;
        step();
        chk("t6_adr3", {7'd0, s_adr}, {7'd0, adr_tab[3]});
        chk("t6_stb3", {31'd0, s_stb}, 32'd1);
        s_ack = 1'b1;
        #1 chk("t6_ack3", {28'd0, m_ack}, 32'b1000);
        step();
        s_ack = 1'b0; m_stb = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
